instr_mem_loader: RTL

//   Write-side companion of the instruction memory. Receives a byte stream over a

---
 rtl/instr_mem_loader_if.sv | 18 +
 rtl/instr_mem_loader.sv | 69 ++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream input and instruction-memory write port of the loader
interface instr_mem_loader_if #(parameter int ADDR_W = 6, parameter int DATA_W = 32);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  modport master (output start, num_words, byte_in, byte_valid,
                  input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done);
  modport slave  (input  start, num_words, byte_in, byte_valid,
                  output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a big-endian byte stream into words and writes them to instruction memory from address 0
module instr_mem_loader #(parameter int ADDR_W = 6, parameter int DATA_W = 32) (
  input logic clk,
  input logic reset,
  instr_mem_loader_if.slave b
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W:0] MAXW = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t state, next;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W-1:0] addr, waddr;
  logic [BC_W-1:0] bcnt;
  logic [DATA_W-1:0] word, wdata, shifted;
  logic take, last_byte, last_word;
  assign take = (state == RECV) && b.byte_valid;
  assign last_byte = bcnt == BC_W'(BYTES - 1);
  assign last_word = ({1'b0, addr} + ONE) == cnt;
  assign shifted = DATA_W'({word, b.byte_in});
  assign b.byte_ready = state == RECV;
  assign b.mem_we = state == WRITE;
  assign b.busy = state != IDLE;
  assign b.cpu_hold = state != IDLE;
  assign b.done = state == DONE;
  assign b.mem_addr = waddr;
  assign b.mem_wdata = wdata;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = b.start ? ((b.num_words == '0) ? DONE : RECV) : IDLE;
      RECV:  next = (take && last_byte) ? WRITE : RECV;
      WRITE: next = last_word ? DONE : RECV;
      DONE:  next = IDLE;
    endcase
  end
  // write port registers are loaded with the completed word so they hold between writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      bcnt <= '0;
      word <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= next;
      if (state == IDLE && b.start) begin
        cnt <= (b.num_words > MAXW) ? MAXW : b.num_words;
        addr <= '0;
        bcnt <= '0;
      end
      if (take) begin
        word <= shifted;
        bcnt <= last_byte ? '0 : bcnt + BC_W'(1);
        if (last_byte) begin
          waddr <= addr;
          wdata <= shifted;
        end
      end
      if (state == WRITE && !last_word) begin
        addr <= addr + ADDR_W'(1);
        bcnt <= '0;
      end
    end
  end
endmodule
